lc3_trace_buffer: RTL and testbench



---
 rtl/lc3_debug_pkg.sv | 38 +++
 rtl/trace_record_fifo.sv | 48 ++++
 rtl/lc3_trace_buffer.sv | 109 ++++++++++
 tb/tb_lc3_trace_buffer.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/lc3_debug_pkg.sv
// Shared definitions for lc3 debug capture: FETCH encoding, trace record layout,
// serializer states and the record-to-word mapping.
package lc3_debug_pkg;

    localparam logic [5:0] LC3_FETCH_STATE = 6'd18;
    localparam int         WORDS_PER_REC   = 10;
    localparam int         WORD_W          = 16;
    localparam int         NUM_REGS        = 8;
    localparam int         IDX_W           = 4;
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(WORDS_PER_REC - 1);

    // Field order matches word order on the stream: {seq,cs,ns} first, R7 in the top register slot.
    typedef struct packed {
        logic [3:0]                           seq;
        logic [5:0]                           cs;
        logic [5:0]                           ns;
        logic [WORD_W-1:0]                    instr;
        logic [NUM_REGS-1:0][WORD_W-1:0]      regs;
    } trace_rec_t;

    localparam int REC_W = $bits(trace_rec_t);

    typedef enum logic {
        SER_IDLE = 1'b0,
        SER_SEND = 1'b1
    } ser_state_t;

    function automatic logic [WORD_W-1:0] rec_word(input trace_rec_t rec, input logic [IDX_W-1:0] idx);
        logic [IDX_W-1:0] ridx;
        ridx = idx - IDX_W'(2);
        case (idx)
            4'd0:    rec_word = {rec.seq, rec.cs, rec.ns};
            4'd1:    rec_word = rec.instr;
            default: rec_word = rec.regs[ridx[2:0]];
        endcase
    endfunction

endpackage

// File: rtl/trace_record_fifo.sv
// Synchronous record FIFO with combinational head read; a pop in the same cycle
// frees a slot for a push when full.
module trace_record_fifo
    import lc3_debug_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int W     = REC_W
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic                   pop,
    input  logic [W-1:0]           wdata,
    output logic [W-1:0]           rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          do_push, do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/lc3_trace_buffer.sv
// Captures an lc3 debug snapshot on every entry into FETCH, buffers records and
// streams each as ten 16-bit valid/ready words.
module lc3_trace_buffer
    import lc3_debug_pkg::*;
#(
    parameter int         DEPTH       = 8,
    parameter logic [5:0] FETCH_STATE = LC3_FETCH_STATE
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    input  logic [5:0]             debugCurrentState,
    input  logic [5:0]             debugNextState,
    input  logic [15:0]            debugInstruction,
    input  logic [127:0]           debugRegRead,
    input  logic                   clearDrops,
    output logic [15:0]            outData,
    output logic                   outValid,
    output logic                   outLast,
    input  logic                   outReady,
    output logic [15:0]            dropCount,
    output logic                   overflow,
    output logic [$clog2(DEPTH):0] fifoCount
);

    trace_rec_t       rec_in, rec_head;
    ser_state_t       state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [3:0]       seq_q;
    logic             trigger, push, pop, drop, full, empty, accept;

    assign trigger = enable & (debugNextState == FETCH_STATE) & (debugCurrentState != FETCH_STATE);
    assign accept  = outValid & outReady;
    assign pop     = accept & (idx_q == LAST_IDX);
    assign push    = trigger & (~full | pop);
    assign drop    = trigger & full & ~pop;

    assign rec_in = '{seq: seq_q, cs: debugCurrentState, ns: debugNextState,
                      instr: debugInstruction, regs: debugRegRead};

    trace_record_fifo #(.DEPTH(DEPTH), .W(REC_W)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .wdata (rec_in),
        .rdata (rec_head),
        .full  (full),
        .empty (empty),
        .count (fifoCount)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            seq_q     <= '0;
            dropCount <= '0;
            overflow  <= 1'b0;
        end else begin
            if (trigger) seq_q <= seq_q + 4'd1;
            if (clearDrops) begin
                dropCount <= '0;
                overflow  <= 1'b0;
            end else if (drop) begin
                if (dropCount != 16'hFFFF) dropCount <= dropCount + 16'd1;
                overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= SER_IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            SER_IDLE: begin
                if (!empty) begin
                    state_d = SER_SEND;
                    idx_d   = '0;
                end
            end
            SER_SEND: begin
                if (accept) begin
                    if (idx_q == LAST_IDX) begin
                        idx_d = '0;
                        // Stay busy when another record remains, including one pushed this cycle.
                        if (fifoCount == ($clog2(DEPTH)+1)'(1) && !push) state_d = SER_IDLE;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            default: state_d = SER_IDLE;
        endcase
    end

    assign outValid = (state_q == SER_SEND);
    assign outLast  = outValid & (idx_q == LAST_IDX);
    assign outData  = outValid ? rec_word(rec_head, idx_q) : 16'h0000;

endmodule

// File: tb/tb_lc3_trace_buffer.sv
// Randomized and directed bench for lc3_trace_buffer against a record-queue reference model.
module tb_lc3_trace_buffer;

    localparam int         DEPTH = 8;
    localparam logic [5:0] FS    = 6'd18;
    localparam int         CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0, reset = 1'b1, enable = 1'b0, clearDrops = 1'b0, outReady = 1'b0;
    logic [5:0]    cs = '0, ns = '0;
    logic [15:0]   ir = '0;
    logic [127:0]  regs = '0;
    logic [15:0]   outData, dropCount;
    logic          outValid, outLast, overflow;
    logic [CW-1:0] fifoCount;

    lc3_trace_buffer #(.DEPTH(DEPTH), .FETCH_STATE(FS)) dut (
        .clk(clk), .reset(reset), .enable(enable),
        .debugCurrentState(cs), .debugNextState(ns), .debugInstruction(ir), .debugRegRead(regs),
        .clearDrops(clearDrops), .outData(outData), .outValid(outValid), .outLast(outLast),
        .outReady(outReady), .dropCount(dropCount), .overflow(overflow), .fifoCount(fifoCount)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Reference model: queue of whole records, word position of the head, counters.
    logic [159:0] mq[$];
    int           m_idx = 0;
    int           prev_cnt = 0;
    logic [3:0]   m_seq = '0;
    logic [15:0]  m_drop = '0;
    logic         m_ovf = 1'b0;
    logic         m_valid = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] word_at(input logic [159:0] r, input int k);
        if (k == 0) return r[159:144];
        if (k == 1) return r[143:128];
        return r[(k-2)*16 +: 16];
    endfunction

    task automatic model_edge();
        bit popped = 0;
        bit dropped = 0;
        if (m_valid && outReady) begin
            m_idx++;
            if (m_idx == 10) begin
                void'(mq.pop_front());
                m_idx = 0;
                popped = 1;
            end
        end
        if (enable && ns == FS && cs != FS) begin
            if (mq.size() < DEPTH) mq.push_back({m_seq, cs, ns, ir, regs});
            else dropped = 1;
            m_seq = m_seq + 4'd1;
        end
        if (clearDrops) begin
            m_drop = '0;
            m_ovf  = 1'b0;
        end else if (dropped) begin
            if (m_drop != 16'hFFFF) m_drop = m_drop + 16'd1;
            m_ovf = 1'b1;
        end
        // A record becomes visible one edge after the queue goes non-empty.
        m_valid  = (mq.size() > 0) && (prev_cnt > 0);
        prev_cnt = mq.size();
    endtask

    task automatic check_outputs();
        chk("outValid", outValid, m_valid);
        chk("outLast", outLast, m_valid && m_idx == 9);
        if (m_valid) chk($sformatf("outData w%0d", m_idx), outData, word_at(mq[0], m_idx));
        chk("fifoCount", fifoCount, mq.size());
        chk("dropCount", dropCount, m_drop);
        chk("overflow", overflow, m_ovf);
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic model_clear();
        mq.delete();
        m_idx = 0; prev_cnt = 0; m_seq = '0; m_drop = '0; m_ovf = 1'b0; m_valid = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        chk("rst outValid", outValid, 0);
        chk("rst outLast", outLast, 0);
        chk("rst outData", outData, 0);
        chk("rst fifoCount", fifoCount, 0);
        chk("rst dropCount", dropCount, 0);
        chk("rst overflow", overflow, 0);
        model_clear();
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic rand_inputs();
        enable = ($urandom_range(0, 9) != 0);
        ns     = ($urandom_range(0, 2) == 0) ? FS : 6'($urandom_range(0, 63));
        cs     = ($urandom_range(0, 7) == 0) ? FS : 6'($urandom_range(0, 63));
        ir     = 16'($urandom);
        regs   = {$urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic fetch_inputs();
        enable = 1'b1; cs = 6'd35; ns = FS; ir = 16'h1261;
        for (int j = 0; j < 8; j++) regs[16*j +: 16] = 16'h0100 + 16'(j);
    endtask

    initial begin
        #2;
        do_reset();

        // Single fetch: latency of two edges, then the fixed word sequence.
        outReady = 1'b1;
        fetch_inputs();
        step();
        ns = 6'd0;
        chk("latency edge1 outValid", outValid, 0);
        step();
        chk("single w0", outData, 16'h08D2);
        for (int k = 0; k < 12; k++) step();

        // Backpressure: alternating ready.
        fetch_inputs();
        step();
        ns = 6'd0;
        for (int k = 0; k < 26; k++) begin
            outReady = ~outReady;
            step();
        end
        outReady = 1'b1;
        for (int k = 0; k < 4; k++) step();

        // Overflow with a stalled consumer, then drain and clear.
        do_reset();
        outReady = 1'b0;
        fetch_inputs();
        for (int k = 0; k < 11; k++) step();
        ns = 6'd0;
        chk("ovf fifoCount", fifoCount, 8);
        chk("ovf dropCount", dropCount, 3);
        chk("ovf overflow", overflow, 1);
        outReady = 1'b1;
        for (int k = 0; k < 85; k++) step();
        clearDrops = 1'b1;
        step();
        clearDrops = 1'b0;
        chk("clear dropCount", dropCount, 0);
        chk("clear overflow", overflow, 0);

        // Full FIFO with trigger landing on the w9 accept.
        outReady = 1'b0;
        fetch_inputs();
        for (int k = 0; k < 8; k++) step();
        ns = 6'd0;
        outReady = 1'b1;
        for (int k = 0; k < 12; k++) begin
            ns = (m_idx == 9 && mq.size() == DEPTH) ? FS : 6'd0;
            step();
        end
        chk("fullpop dropCount", dropCount, 0);
        chk("fullpop fifoCount", fifoCount, 8);
        ns = 6'd0;
        for (int k = 0; k < 90; k++) step();

        // Sequence wrap: 17 records.
        do_reset();
        fetch_inputs();
        for (int k = 0; k < 17; k++) begin
            regs[15:0] = 16'($urandom);
            step();
        end
        ns = 6'd0;
        for (int k = 0; k < 180; k++) step();

        // Random traffic with random backpressure and occasional clears.
        for (int k = 0; k < 800; k++) begin
            rand_inputs();
            outReady   = ($urandom_range(0, 3) != 0);
            clearDrops = ($urandom_range(0, 40) == 0);
            step();
        end
        clearDrops = 1'b0;
        enable = 1'b0;
        outReady = 1'b1;
        for (int k = 0; k < 100; k++) step();

        // Reset in the middle of a record, after w4 accepted.
        fetch_inputs();
        step();
        ns = 6'd0;
        for (int k = 0; k < 20 && m_idx != 5; k++) step();
        chk("midrec index reached", m_idx, 5);
        do_reset();
        chk("post-reset idle", outValid, 0);
        fetch_inputs();
        step();
        ns = 6'd0;
        step();
        chk("post-reset w0", outData, 16'h08D2);
        for (int k = 0; k < 12; k++) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
